// File: rtl/pipereg_wb_skid.sv
// pipereg_wb_skid
//   Multi-lane execute->writeback pipe register. Each lane holds a 2-entry skid
//   buffer (main + skid) with valid/ready handshake, squashes entries younger
//   than a flush robid in place, and the top exposes one arbitrated redirect
//   (oldest valid redirecting head) for the frontend.
// Ports
//   clock, reset_n            clock / async active-low reset
//   in_*                      per-lane execute result, lane l at [l*W +: W]
//   in_ready                  lane can accept (registered: skid slot empty)
//   flush_valid, flush_robid  squash everything strictly younger than flush_robid
//   out_*                     per-lane head entry, packed like in_*
//   out_ready                 consumer takes the head of that lane
//   redir_valid/target/robid  oldest valid head that redirects (0 when none)

// One lane: main register drives the outputs, skid catches the beat that
// arrives while the consumer stalls. State is {main_v, skid_v}; (0,1) never occurs.
module pipereg_wb_lane #(
   parameter int PREG_W  = 6,
   parameter int DATA_W  = 64,
   parameter int ROB_LOG = 6,
   localparam int RW = ROB_LOG + 1,
   localparam int PW = 1 + PREG_W + DATA_W + 1 + DATA_W + RW + DATA_W
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   input  logic          flush_valid,
   input  logic [RW-1:0] flush_robid,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_data
);
   typedef struct packed {
      logic              need_to_wb;
      logic [PREG_W-1:0] prd;
      logic [DATA_W-1:0] result;
      logic              redirect_valid;
      logic [DATA_W-1:0] redirect_target;
      logic [RW-1:0]     robid;
      logic [DATA_W-1:0] pc;
   } wb_ent_t;

   // Wrap-aware: differing wrap bits invert the sense of the index compare.
   function automatic logic younger(input logic [RW-1:0] a, input logic [RW-1:0] b);
      return (a[RW-1] ^ b[RW-1]) ^ (a[RW-2:0] > b[RW-2:0]);
   endfunction

   wb_ent_t in_ent, main_q, skid_q;
   logic    main_v, skid_v;
   logic    killed_in, push, pop, main_alive, skid_alive;

   assign in_ent    = in_data;
   assign in_ready  = !skid_v;
   assign out_valid = main_v;
   assign out_data  = main_q;

   always_comb begin
      killed_in  = flush_valid & younger(in_ent.robid, flush_robid);
      push       = in_valid & in_ready & !killed_in;
      pop        = main_v & out_ready;
      // An entry survives the edge if it is neither consumed nor squashed.
      main_alive = main_v & !pop & !(flush_valid & younger(main_q.robid, flush_robid));
      skid_alive = skid_v & !(flush_valid & younger(skid_q.robid, flush_robid));
   end

   // push implies skid empty, so push and a surviving skid never coincide.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else if (main_alive) begin
         main_v <= 1'b1;
         skid_v <= skid_alive | push;
         if (push) skid_q <= in_ent;
      end else if (skid_alive) begin
         // Head gone (popped or squashed): skid compacts into main.
         main_v <= 1'b1;
         skid_v <= 1'b0;
         main_q <= skid_q;
      end else begin
         main_v <= push;
         skid_v <= 1'b0;
         if (push) main_q <= in_ent;
      end
   end
endmodule

module pipereg_wb_skid #(
   parameter int LANES   = 2,
   parameter int PREG_W  = 6,
   parameter int ROB_LOG = 6,
   parameter int DATA_W  = 64
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [LANES-1:0]           in_valid,
   output logic [LANES-1:0]           in_ready,
   input  logic [LANES-1:0]           in_need_to_wb,
   input  logic [LANES*PREG_W-1:0]    in_prd,
   input  logic [LANES*DATA_W-1:0]    in_result,
   input  logic [LANES-1:0]           in_redirect_valid,
   input  logic [LANES*DATA_W-1:0]    in_redirect_target,
   input  logic [LANES*(ROB_LOG+1)-1:0] in_robid,
   input  logic [LANES*DATA_W-1:0]    in_pc,
   input  logic                       flush_valid,
   input  logic [ROB_LOG:0]           flush_robid,
   output logic [LANES-1:0]           out_valid,
   input  logic [LANES-1:0]           out_ready,
   output logic [LANES-1:0]           out_need_to_wb,
   output logic [LANES*PREG_W-1:0]    out_prd,
   output logic [LANES*DATA_W-1:0]    out_result,
   output logic [LANES-1:0]           out_redirect_valid,
   output logic [LANES*DATA_W-1:0]    out_redirect_target,
   output logic [LANES*(ROB_LOG+1)-1:0] out_robid,
   output logic [LANES*DATA_W-1:0]    out_pc,
   output logic                       redir_valid,
   output logic [DATA_W-1:0]          redir_target,
   output logic [ROB_LOG:0]           redir_robid
);
   localparam int RW = ROB_LOG + 1;
   localparam int PW = 1 + PREG_W + DATA_W + 1 + DATA_W + RW + DATA_W;

   function automatic logic younger(input logic [RW-1:0] a, input logic [RW-1:0] b);
      return (a[RW-1] ^ b[RW-1]) ^ (a[RW-2:0] > b[RW-2:0]);
   endfunction

   logic [LANES-1:0][PW-1:0] lane_in, lane_out;

   // Field order here must match the lane's entry struct.
   for (genvar l = 0; l < LANES; l++) begin : g_pack
      assign lane_in[l] = {in_need_to_wb[l], in_prd[l*PREG_W +: PREG_W],
                           in_result[l*DATA_W +: DATA_W], in_redirect_valid[l],
                           in_redirect_target[l*DATA_W +: DATA_W],
                           in_robid[l*RW +: RW], in_pc[l*DATA_W +: DATA_W]};
      assign {out_need_to_wb[l], out_prd[l*PREG_W +: PREG_W],
              out_result[l*DATA_W +: DATA_W], out_redirect_valid[l],
              out_redirect_target[l*DATA_W +: DATA_W],
              out_robid[l*RW +: RW], out_pc[l*DATA_W +: DATA_W]} = lane_out[l];
   end

   pipereg_wb_lane #(
      .PREG_W (PREG_W),
      .DATA_W (DATA_W),
      .ROB_LOG(ROB_LOG)
   ) u_lane[LANES-1:0] (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (lane_in),
      .flush_valid(flush_valid),
      .flush_robid(flush_robid),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (lane_out)
   );

   // Oldest redirecting head wins; a candidate replaces the current pick only
   // if strictly older, so equal robids stay with the lower lane.
   always_comb begin
      redir_valid  = 1'b0;
      redir_target = '0;
      redir_robid  = '0;
      for (int l = 0; l < LANES; l++) begin
         if (out_valid[l] && out_redirect_valid[l]) begin
            if (!redir_valid || younger(redir_robid, out_robid[l*RW +: RW])) begin
               redir_valid  = 1'b1;
               redir_target = out_redirect_target[l*DATA_W +: DATA_W];
               redir_robid  = out_robid[l*RW +: RW];
            end
         end
      end
   end
endmodule

// File: tb/tb_pipereg_wb_skid.sv
module tb_pipereg_wb_skid;
   localparam int L = 2, PW = 6, RW = 7, DW = 64;

   logic            clock, reset_n;
   logic [L-1:0]    in_valid, in_ready, in_need_to_wb, in_redirect_valid;
   logic [L*PW-1:0] in_prd, out_prd;
   logic [L*DW-1:0] in_result, in_redirect_target, in_pc;
   logic [L*RW-1:0] in_robid, out_robid;
   logic            flush_valid;
   logic [RW-1:0]   flush_robid, redir_robid;
   logic [L-1:0]    out_valid, out_ready, out_need_to_wb, out_redirect_valid;
   logic [L*DW-1:0] out_result, out_redirect_target, out_pc;
   logic            redir_valid;
   logic [DW-1:0]   redir_target;

   pipereg_wb_skid dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_need_to_wb(in_need_to_wb),
      .in_prd(in_prd), .in_result(in_result), .in_redirect_valid(in_redirect_valid),
      .in_redirect_target(in_redirect_target), .in_robid(in_robid), .in_pc(in_pc),
      .flush_valid(flush_valid), .flush_robid(flush_robid),
      .out_valid(out_valid), .out_ready(out_ready), .out_need_to_wb(out_need_to_wb),
      .out_prd(out_prd), .out_result(out_result), .out_redirect_valid(out_redirect_valid),
      .out_redirect_target(out_redirect_target), .out_robid(out_robid), .out_pc(out_pc),
      .redir_valid(redir_valid), .redir_target(redir_target), .redir_robid(redir_robid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [RW-1:0] robid;
      logic [DW-1:0] result;
   } exp_t;
   exp_t q0[$];
   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int l, input bit v, input logic [RW-1:0] rid,
                      input logic [DW-1:0] res, input bit rv, input logic [DW-1:0] tgt);
      in_valid[l]                  = v;
      in_robid[l*RW +: RW]         = rid;
      in_result[l*DW +: DW]        = res;
      in_redirect_valid[l]         = rv;
      in_redirect_target[l*DW +: DW] = tgt;
      in_prd[l*PW +: PW]           = rid[5:0];
      in_need_to_wb[l]             = 1'b1;
      in_pc[l*DW +: DW]            = {57'd0, rid};
   endtask

   // Lane-0 scoreboard: compare any pop happening at the coming edge against the
   // oldest expected entry, then record the input we expect the lane to accept.
   task automatic tick(input bit acc0, input bit rdy0);
      exp_t e;
      if (in_valid[0]) chk("in_ready0", {63'd0, in_ready[0]}, {63'd0, rdy0});
      if (out_valid[0] && out_ready[0]) begin
         tests++;
         assert (q0.size() != 0) else begin
            fails++;
            $error("FAIL spurious_pop observed=%0h expected=none", out_robid[RW-1:0]);
         end
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("pop_robid", {57'd0, out_robid[RW-1:0]}, {57'd0, e.robid});
            chk("pop_result", out_result[DW-1:0], e.result);
         end
      end
      if (acc0) begin
         e.robid  = in_robid[RW-1:0];
         e.result = in_result[DW-1:0];
         q0.push_back(e);
      end
      @(posedge clock); #1;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = '0; in_need_to_wb = '0; in_prd = '0; in_result = '0;
      in_redirect_valid = '0; in_redirect_target = '0; in_robid = '0; in_pc = '0;
      flush_valid = 1'b0; flush_robid = '0; out_ready = '0;
      #12;
      chk("rst_out_valid", {62'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {62'd0, in_ready}, 64'd3);
      chk("rst_redir_valid", {63'd0, redir_valid}, 64'd0);
      chk("rst_out_robid", {50'd0, out_robid}, 64'd0);
      chk("rst_out_result", out_result[DW-1:0], 64'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // streaming
      out_ready = 2'b01;
      drv(0, 1, 7'd5, 64'h50, 0, 0); tick(1, 1);
      chk("stream_first_valid", {63'd0, out_valid[0]}, 64'd1);
      chk("stream_first_robid", {57'd0, out_robid[RW-1:0]}, 64'd5);
      drv(0, 1, 7'd6, 64'h60, 0, 0); tick(1, 1);
      chk("stream_second_robid", {57'd0, out_robid[RW-1:0]}, 64'd6);
      drv(0, 1, 7'd7, 64'h70, 0, 0); tick(1, 1);
      chk("stream_third_robid", {57'd0, out_robid[RW-1:0]}, 64'd7);
      in_valid = '0; tick(0, 0);
      chk("stream_drained", {63'd0, out_valid[0]}, 64'd0);

      // backpressure
      out_ready = '0;
      drv(0, 1, 7'd3, 64'h33, 0, 0); tick(1, 1);
      drv(0, 1, 7'd4, 64'h44, 0, 0); tick(1, 1);
      chk("bp_full_in_ready", {63'd0, in_ready[0]}, 64'd0);
      chk("bp_head_robid", {57'd0, out_robid[RW-1:0]}, 64'd3);
      in_valid = '0; out_ready = 2'b01; tick(0, 0);
      chk("bp_shift_robid", {57'd0, out_robid[RW-1:0]}, 64'd4);
      chk("bp_one_in_ready", {63'd0, in_ready[0]}, 64'd1);
      tick(0, 0);
      chk("bp_empty", {63'd0, out_valid[0]}, 64'd0);
      chk("bp_no_leftover", 64'(q0.size()), 64'd0);

      // flush across ROB wrap
      out_ready = '0;
      drv(0, 1, 7'h7E, 64'hE0, 0, 0); drv(1, 1, 7'h01, 64'h01, 0, 0); tick(1, 1);
      chk("wrap_lane1_loaded", {57'd0, out_robid[2*RW-1:RW]}, 64'h01);
      in_valid[1] = 1'b0;
      drv(0, 1, 7'h02, 64'h02, 0, 0); flush_valid = 1'b1; flush_robid = 7'h7E;
      tick(0, 1);
      flush_valid = 1'b0; in_valid = '0;
      chk("wrap_keep_valid", {63'd0, out_valid[0]}, 64'd1);
      chk("wrap_keep_robid", {57'd0, out_robid[RW-1:0]}, 64'h7E);
      chk("wrap_input_dropped", {63'd0, in_ready[0]}, 64'd1);
      chk("wrap_lane1_squashed", {63'd0, out_valid[1]}, 64'd0);
      out_ready = 2'b11; tick(0, 0);
      chk("wrap_drained", {62'd0, out_valid}, 64'd0);

      // flush compaction: main younger, skid older than flush id
      out_ready = '0;
      drv(0, 1, 7'd9, 64'h99, 0, 0); tick(1, 1);
      drv(0, 1, 7'd4, 64'h04, 0, 0); tick(1, 1);
      in_valid = '0; flush_valid = 1'b1; flush_robid = 7'd5; tick(0, 0);
      flush_valid = 1'b0;
      void'(q0.pop_front());  // robid 9 is squashed
      chk("compact_valid", {63'd0, out_valid[0]}, 64'd1);
      chk("compact_robid", {57'd0, out_robid[RW-1:0]}, 64'd4);
      chk("compact_in_ready", {63'd0, in_ready[0]}, 64'd1);
      out_ready = 2'b01; tick(0, 0);
      chk("compact_drained", {63'd0, out_valid[0]}, 64'd0);

      // redirect arbitration
      out_ready = '0;
      drv(0, 1, 7'd20, 64'h20, 1, 64'h1000); drv(1, 1, 7'd12, 64'h12, 1, 64'h2000);
      tick(1, 1);
      in_valid = '0;
      chk("arb_valid", {63'd0, redir_valid}, 64'd1);
      chk("arb_target", redir_target, 64'h2000);
      chk("arb_robid", {57'd0, redir_robid}, 64'd12);
      out_ready = 2'b10; tick(0, 0);
      chk("arb_next_target", redir_target, 64'h1000);
      chk("arb_next_robid", {57'd0, redir_robid}, 64'd20);
      out_ready = 2'b01; tick(0, 0);
      chk("arb_none_valid", {63'd0, redir_valid}, 64'd0);
      chk("arb_none_target", redir_target, 64'd0);
      chk("arb_none_robid", {57'd0, redir_robid}, 64'd0);

      // async reset mid-stream
      out_ready = '0;
      drv(0, 1, 7'd30, 64'h30, 1, 64'h3000); tick(1, 1);
      drv(0, 1, 7'd31, 64'h31, 0, 0); tick(1, 1);
      chk("pre_rst_full", {63'd0, in_ready[0]}, 64'd0);
      in_valid = '0;
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {62'd0, out_valid}, 64'd0);
      chk("mid_rst_in_ready", {62'd0, in_ready}, 64'd3);
      chk("mid_rst_redir", {63'd0, redir_valid}, 64'd0);
      q0.delete();
      #10;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
